// File: rtl/bram_buf_pkg.sv
// Shared frame-buffer geometry, slot encodings and scheduler states
// for the BRAM access scheduler and its helpers.
package bram_buf_pkg;
  localparam int BUFW     = 64;
  localparam int BUFH     = 64;
  localparam int WADDR    = $clog2(BUFW * BUFH);
  localparam int COL_BITS = $clog2(BUFW);
  localparam int RGB_W    = 12;
  localparam int ADDR_W   = 7;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_DISP,
    SLOT_CLR,
    SLOT_WR
  } slot_t;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;
endpackage

// File: rtl/bram_access_sched_win_map.sv
// Display window test and screen-to-buffer coordinate mapping.
// Purely combinational so an overlay stage can reuse it.
module win_map
  import bram_buf_pkg::*;
#(
  parameter int SCALE_LOG2 = 2,
  parameter int X0         = 192,
  parameter int Y0         = 112
) (
  input  logic [9:0]        i_px_x,
  input  logic [9:0]        i_px_y,
  input  logic              i_px_active,
  output logic              o_in_win,
  output logic [ADDR_W-1:0] o_row,
  output logic [ADDR_W-1:0] o_col
);
  localparam logic [10:0] WIN_W = 11'(BUFW << SCALE_LOG2);
  localparam logic [10:0] WIN_H = 11'(BUFH << SCALE_LOG2);

  logic [10:0] w_dx;
  logic [10:0] w_dy;

  // 11-bit unsigned: anything left of / above the window wraps large
  assign w_dx = {1'b0, i_px_x} - 11'(X0);
  assign w_dy = {1'b0, i_px_y} - 11'(Y0);

  assign o_in_win = i_px_active && (w_dx < WIN_W) && (w_dy < WIN_H);
  assign o_row    = ADDR_W'(w_dy >> SCALE_LOG2);
  assign o_col    = ADDR_W'(w_dx >> SCALE_LOG2);
endmodule

// File: rtl/bram_access_sched.sv
// Fixed-priority scheduler for the frame buffer's single address port:
// display reads, then clear sweep, then single-pixel writes.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | no sweep; free non-window slots go to the writer
// ST_CLEAR | sweeping clr_cnt over every address on free slots
module bram_access_sched
  import bram_buf_pkg::*;
#(
  parameter int SCALE_LOG2 = 2,
  parameter int X0         = 192,
  parameter int Y0         = 112
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [9:0]        px_x,
  input  logic [9:0]        px_y,
  input  logic              px_active,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_row,
  input  logic [ADDR_W-1:0] wr_col,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              we,
  input  logic [RGB_W-1:0]  rgb_in,
  output logic [RGB_W-1:0]  pix_rgb,
  output logic              pix_valid
);
  localparam logic [WADDR-1:0] CLR_LAST = WADDR'(BUFW * BUFH - 1);

  logic              w_in_win;
  logic [ADDR_W-1:0] w_disp_row;
  logic [ADDR_W-1:0] w_disp_col;
  slot_t             w_slot;
  state_t            r_state;
  logic [WADDR-1:0]  r_clr_cnt;
  logic              r_win_d1;
  logic              r_win_d2;

  win_map #(
    .SCALE_LOG2(SCALE_LOG2),
    .X0        (X0),
    .Y0        (Y0)
  ) u_win_map (
    .i_px_x     (px_x),
    .i_px_y     (px_y),
    .i_px_active(px_active),
    .o_in_win   (w_in_win),
    .o_row      (w_disp_row),
    .o_col      (w_disp_col)
  );

  // A request still high during its own ack cycle is the same request;
  // a clear_start cycle also withholds the slot so the sweep wins.
  always_comb begin
    w_slot = SLOT_IDLE;
    if (w_in_win)
      w_slot = SLOT_DISP;
    else if (r_state == ST_CLEAR)
      w_slot = SLOT_CLR;
    else if (wr_req && !wr_ack && !clear_start)
      w_slot = SLOT_WR;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= '0;
      r_win_d1   <= 1'b0;
      r_win_d2   <= 1'b0;
      row        <= '0;
      col        <= '0;
      we         <= 1'b0;
      wr_ack     <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      pix_rgb    <= '0;
      pix_valid  <= 1'b0;
    end else begin
      we         <= 1'b0;
      wr_ack     <= 1'b0;
      clear_done <= 1'b0;
      r_win_d1   <= w_in_win;
      r_win_d2   <= r_win_d1;
      pix_valid  <= r_win_d2;
      pix_rgb    <= r_win_d2 ? rgb_in : '0;

      case (w_slot)
        SLOT_DISP: begin
          row <= w_disp_row;
          col <= w_disp_col;
        end
        SLOT_CLR: begin
          row       <= ADDR_W'(r_clr_cnt >> COL_BITS);
          col       <= ADDR_W'(r_clr_cnt[COL_BITS-1:0]);
          we        <= 1'b1;
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == CLR_LAST) begin
            r_state    <= ST_IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        SLOT_WR: begin
          row    <= wr_row;
          col    <= wr_col;
          we     <= 1'b1;
          wr_ack <= 1'b1;
        end
        default: ;
      endcase

      if (r_state == ST_IDLE && clear_start) begin
        r_state    <= ST_CLEAR;
        r_clr_cnt  <= '0;
        clear_busy <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bram_access_sched.sv
// Scoreboard bench for bram_access_sched: a behavioural model predicts
// every address-port cycle and every pixel; a monitor pops and compares.
module tb_bram_access_sched;
  logic        clk;
  logic        resetn;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        px_active;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic        wr_req;
  logic [6:0]  wr_row;
  logic [6:0]  wr_col;
  logic        wr_ack;
  logic [6:0]  row;
  logic [6:0]  col;
  logic        we;
  logic [11:0] rgb_in;
  logic [11:0] pix_rgb;
  logic        pix_valid;

  bram_access_sched dut (
    .clk        (clk),
    .resetn     (resetn),
    .px_x       (px_x),
    .px_y       (px_y),
    .px_active  (px_active),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .wr_req     (wr_req),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_ack     (wr_ack),
    .row        (row),
    .col        (col),
    .we         (we),
    .rgb_in     (rgb_in),
    .pix_rgb    (pix_rgb),
    .pix_valid  (pix_valid)
  );

  typedef struct packed {
    logic [6:0] row;
    logic [6:0] col;
    logic       we;
    logic       ack;
    logic       busy;
    logic       done;
  } bus_t;

  typedef struct packed {
    logic        valid;
    logic [11:0] rgb;
  } pix_t;

  bus_t        bq[$];
  pix_t        pq[$];
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 0;
  logic [11:0] salt;
  int          got_done = 0;
  int          got_ack = 0;
  int          exp_done = 0;
  int          exp_ack = 0;

  // reference model state
  bit m_busy;
  int m_next;
  bit m_ack_last;
  int m_row;
  int m_col;

  // random requester state
  bit w_pend;
  int w_r;
  int w_c;
  bit g1;
  bit g2;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // BRAM stand-in: content is a salted function of the address, 1-cycle latency
  always @(posedge clk) rgb_in <= {row[5:0], col[5:0]} ^ salt;

  function automatic logic [11:0] mem_of(input int r, input int c);
    return 12'(r * 64 + c) ^ salt;
  endfunction

  task automatic step(input int x, input int y, input bit act, input bit clr,
                      input bit wreq, input int wr_r, input int wr_c);
    int   dx;
    int   dy;
    bit   win;
    bit   busy_pre;
    bus_t e;
    pix_t p;
    px_x        = 10'(x);
    px_y        = 10'(y);
    px_active   = act;
    clear_start = clr;
    wr_req      = wreq;
    wr_row      = 7'(wr_r);
    wr_col      = 7'(wr_c);

    dx       = x - 192;
    dy       = y - 112;
    win      = act && dx >= 0 && dx < 256 && dy >= 0 && dy < 256;
    busy_pre = m_busy;
    e        = '0;
    if (win) begin
      m_row = dy / 4;
      m_col = dx / 4;
    end else if (m_busy) begin
      m_row = m_next / 64;
      m_col = m_next % 64;
      e.we  = 1;
      if (m_next == 4095) begin
        m_busy = 0;
        e.done = 1;
        exp_done++;
      end
      m_next++;
    end else if (wreq && !m_ack_last && !clr) begin
      m_row = wr_r;
      m_col = wr_c;
      e.we  = 1;
      e.ack = 1;
      exp_ack++;
    end
    if (clr && !busy_pre) begin
      m_busy = 1;
      m_next = 0;
    end
    m_ack_last = e.ack;
    e.row  = 7'(m_row);
    e.col  = 7'(m_col);
    e.busy = m_busy;
    bq.push_back(e);
    p.valid = win;
    p.rgb   = win ? mem_of(dy / 4, dx / 4) : 12'h000;
    pq.push_back(p);
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    chk_en      = 0;
    px_active   = 0;
    clear_start = 0;
    #2 resetn = 0;
    #1;
    total++;
    if ({row, col, we, wr_ack, clear_busy, clear_done, pix_rgb, pix_valid} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got row=%0d col=%0d we=%0b ack=%0b busy=%0b done=%0b rgb=%h valid=%0b want all zero",
               row, col, we, wr_ack, clear_busy, clear_done, pix_rgb, pix_valid);
    end
    repeat (hold) @(negedge clk);
    bq.delete();
    pq.delete();
    pq.push_back('0);
    pq.push_back('0);
    m_busy     = 0;
    m_next     = 0;
    m_ack_last = 0;
    m_row      = 0;
    m_col      = 0;
    g1         = 0;
    g2         = 0;
    resetn     = 1;
    chk_en     = 1;
  endtask

  // monitor
  initial begin
    bus_t e;
    pix_t p;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        total++;
        if (bq.size() == 0) begin
          bad++;
          $display("FAIL bus_queue: DUT cycle with no expected entry");
        end else begin
          e = bq.pop_front();
          if ({row, col, we, wr_ack, clear_busy, clear_done} !== e) begin
            bad++;
            $display("FAIL bus t=%0t: got row=%0d col=%0d we=%0b ack=%0b busy=%0b done=%0b want row=%0d col=%0d we=%0b ack=%0b busy=%0b done=%0b",
                     $time, row, col, we, wr_ack, clear_busy, clear_done,
                     e.row, e.col, e.we, e.ack, e.busy, e.done);
          end
        end
        total++;
        if (pq.size() == 0) begin
          bad++;
          $display("FAIL pix_queue: DUT cycle with no expected pixel");
        end else begin
          p = pq.pop_front();
          if ({pix_valid, pix_rgb} !== p) begin
            bad++;
            $display("FAIL pix t=%0t: got valid=%0b rgb=%h want valid=%0b rgb=%h",
                     $time, pix_valid, pix_rgb, p.valid, p.rgb);
          end
        end
        if (clear_done) got_done++;
        if (wr_ack) got_ack++;
      end
    end
  end

  initial begin
    int guard;
    salt        = 12'($urandom);
    resetn      = 0;
    px_x        = 0;
    px_y        = 0;
    px_active   = 0;
    clear_start = 0;
    wr_req      = 0;
    wr_row      = 0;
    wr_col      = 0;
    w_pend      = 0;
    w_r         = 0;
    w_c         = 0;
    @(negedge clk);
    do_reset(3);

    // window mapping and edges
    step(192, 112, 1, 0, 0, 0, 0);
    step(447, 367, 1, 0, 0, 0, 0);
    step(448, 367, 1, 0, 0, 0, 0);
    step(191, 112, 1, 0, 0, 0, 0);
    step(192, 111, 1, 0, 0, 0, 0);
    step(300, 368, 1, 0, 0, 0, 0);
    step(300, 200, 0, 0, 0, 0, 0);
    step(257, 181, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    // writer in blanking: held through the ack cycle, then dropped
    step(0, 0, 0, 0, 1, 5, 9);
    step(0, 0, 0, 0, 1, 5, 9);
    step(0, 0, 0, 0, 0, 5, 9);
    // back-to-back: still high after the ack is a new request
    repeat (4) step(0, 0, 0, 0, 1, 17, 100);
    step(0, 0, 0, 0, 0, 0, 0);

    // writer starved across 256 in-window cycles
    for (int i = 0; i < 256; i++) step(192 + i, 200, 1, 0, 1, 33, 44);
    step(0, 200, 0, 0, 1, 33, 44);
    step(0, 200, 0, 0, 1, 33, 44);
    step(0, 200, 0, 0, 0, 0, 0);

    // full clear in blanking
    step(0, 0, 0, 1, 0, 0, 0);
    guard = 0;
    while (m_busy && guard < 5000) begin
      step(0, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    // clear vs writer, second clear_start at count 100, some window cycles
    step(0, 0, 0, 1, 1, 7, 8);
    guard = 0;
    while (!m_ack_last && guard < 12000) begin
      if (m_busy && m_next == 100)
        step(0, 0, 0, 1, 1, 7, 8);
      else if ($urandom % 4 == 0)
        step($urandom_range(192, 447), $urandom_range(112, 367), 1, 0, 1, 7, 8);
      else
        step(0, 0, 0, 0, 1, 7, 8);
      guard++;
    end
    step(0, 0, 0, 0, 1, 7, 8);
    step(0, 0, 0, 0, 0, 0, 0);

    // reset mid-clear, then writer acked on the first free slot
    step(0, 0, 0, 1, 0, 0, 0);
    guard = 0;
    while (m_next < 2000 && guard < 5000) begin
      step(0, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    do_reset(2);
    step(0, 0, 0, 0, 1, 20, 30);
    step(0, 0, 0, 0, 1, 20, 30);
    step(0, 0, 0, 0, 0, 0, 0);

    // randomized traffic
    g1 = 0;
    g2 = 0;
    w_pend = 0;
    for (int i = 0; i < 4000; i++) begin
      if (g2 || !w_pend) begin
        w_pend = ($urandom % 3 == 0);
        w_r = $urandom_range(0, 127);
        w_c = $urandom_range(0, 127);
      end
      step($urandom_range(150, 500), $urandom_range(90, 400), ($urandom % 4 != 0),
           ($urandom % 700 == 0), w_pend, w_r, w_c);
      g2 = g1;
      g1 = m_ack_last;
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    total++;
    if (got_done != exp_done) begin
      bad++;
      $display("FAIL clear_done_count: got %0d want %0d", got_done, exp_done);
    end
    total++;
    if (got_ack != exp_ack) begin
      bad++;
      $display("FAIL wr_ack_count: got %0d want %0d", got_ack, exp_ack);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
